// File: rtl/mem_access_if.sv
// Bundle of the MEM-stage command inputs, the data-bus req/ack handshake,
// the pipeline stall and the MEM/WB write-back command.
// Handshake: bus_req is raised with bus_we/bus_addr/bus_sel/bus_wdata and all
// of them stay stable until the cycle in which bus_ack is sampled high
// (bus_rdata valid in that same cycle) or until the access times out.
// bus_ack seen while bus_req is low is ignored.
interface mem_access_if;
    logic        mem_memWriteEnable;
    logic        mem_memReadEnable;
    logic [29:0] mem_memAddr;
    logic [3:0]  mem_memSel;
    logic [31:0] mem_result;
    logic [4:0]  mem_regDest;
    logic        mem_resultSel;
    logic        mem_loadSigned;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_req;
    logic        bus_err;
    logic        wb_writeEnable;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_data;

    // Controller side
    modport master (
        input  mem_memWriteEnable, mem_memReadEnable, mem_memAddr, mem_memSel,
        input  mem_result, mem_regDest, mem_resultSel, mem_loadSigned,
        input  bus_rdata, bus_ack,
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output stall_req, bus_err, wb_writeEnable, wb_regDest, wb_data
    );

    // Pipeline / memory side
    modport slave (
        output mem_memWriteEnable, mem_memReadEnable, mem_memAddr, mem_memSel,
        output mem_result, mem_regDest, mem_resultSel, mem_loadSigned,
        output bus_rdata, bus_ack,
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  stall_req, bus_err, wb_writeEnable, wb_regDest, wb_data
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage memory access controller: issues loads/stores on a req/ack bus,
// stalls the pipeline while an access is outstanding, aligns/extends load
// data and registers the write-back command for the MEM/WB stage.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.master      io_if,
    output logic [1:0]        o_dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [CW-1:0] r_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [29:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic        r_bus_err;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_is_load;
    logic [4:0]  r_rd;
    logic        r_signed;
    logic        r_rsel;
    logic [31:0] r_result;

    logic        w_cmd;
    logic        w_ack_hit;
    logic        w_timeout;
    logic        w_stall;
    logic [31:0] w_store_data;
    logic [31:0] w_load_data;

    assign w_cmd = io_if.mem_memWriteEnable | io_if.mem_memReadEnable;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an ack in the final timeout cycle completes normally
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd) w_next_state = S_BUSY;
            S_BUSY:  if (w_ack_hit || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-derived outputs: completion/timeout qualifiers and pipeline stall
    always_comb begin
        w_ack_hit = 1'b0;
        w_timeout = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            S_IDLE: w_stall = w_cmd;
            S_BUSY: begin
                w_stall   = 1'b1;
                w_ack_hit = io_if.bus_ack;
                w_timeout = !io_if.bus_ack && (r_cnt == CW'(TIMEOUT - 1));
            end
            default: w_stall = 1'b0;
        endcase
        // Reset drops the stall immediately, even mid-access
        if (!rst) w_stall = 1'b0;
    end

    // Store data replicated across the lanes the byte select will pick from
    always_comb begin
        w_store_data = io_if.mem_result;
        case (io_if.mem_memSel)
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: w_store_data = {4{io_if.mem_result[7:0]}};
            4'b0011, 4'b1100: w_store_data = {2{io_if.mem_result[15:0]}};
            default:          w_store_data = io_if.mem_result;
        endcase
    end

    // Load alignment to bit 0 plus sign/zero extension of sub-word loads
    always_comb begin
        w_load_data = io_if.bus_rdata;
        case (r_bus_sel)
            4'b0001: w_load_data = {{24{r_signed & io_if.bus_rdata[7]}},  io_if.bus_rdata[7:0]};
            4'b0010: w_load_data = {{24{r_signed & io_if.bus_rdata[15]}}, io_if.bus_rdata[15:8]};
            4'b0100: w_load_data = {{24{r_signed & io_if.bus_rdata[23]}}, io_if.bus_rdata[23:16]};
            4'b1000: w_load_data = {{24{r_signed & io_if.bus_rdata[31]}}, io_if.bus_rdata[31:24]};
            4'b0011: w_load_data = {{16{r_signed & io_if.bus_rdata[15]}}, io_if.bus_rdata[15:0]};
            4'b1100: w_load_data = {{16{r_signed & io_if.bus_rdata[31]}}, io_if.bus_rdata[31:16]};
            default: w_load_data = io_if.bus_rdata;
        endcase
    end

    // Bus, timeout counter and write-back registers, sequenced by the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            r_signed    <= 1'b0;
            r_rsel      <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bus_err <= 1'b0;
                    if (w_cmd) begin
                        // Write wins when both enables are set
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= io_if.mem_memWriteEnable;
                        r_bus_addr  <= io_if.mem_memAddr;
                        r_bus_sel   <= io_if.mem_memSel;
                        r_bus_wdata <= w_store_data;
                        r_cnt       <= '0;
                        r_wb_we     <= 1'b0;
                        r_is_load   <= !io_if.mem_memWriteEnable;
                        r_rd        <= io_if.mem_regDest;
                        r_signed    <= io_if.mem_loadSigned;
                        r_rsel      <= io_if.mem_resultSel;
                        r_result    <= io_if.mem_result;
                    end else begin
                        r_wb_rd   <= io_if.mem_regDest;
                        r_wb_data <= io_if.mem_result;
                        r_wb_we   <= (io_if.mem_regDest != 5'd0);
                    end
                end
                S_BUSY: begin
                    if (w_ack_hit) begin
                        r_bus_req <= 1'b0;
                        if (r_is_load) begin
                            r_wb_we   <= (r_rd != 5'd0);
                            r_wb_rd   <= r_rd;
                            r_wb_data <= r_rsel ? w_load_data : r_result;
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_wb_we   <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_wb_we   <= 1'b0;
                    r_bus_err <= 1'b0;
                end
            endcase
        end
    end

    assign io_if.bus_req        = r_bus_req;
    assign io_if.bus_we         = r_bus_we;
    assign io_if.bus_addr       = r_bus_addr;
    assign io_if.bus_sel        = r_bus_sel;
    assign io_if.bus_wdata      = r_bus_wdata;
    assign io_if.bus_err        = r_bus_err;
    assign io_if.stall_req      = w_stall;
    assign io_if.wb_writeEnable = r_wb_we;
    assign io_if.wb_regDest     = r_wb_rd;
    assign io_if.wb_data        = r_wb_data;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access, run with a short timeout of 4 cycles.
module tb_mem_access;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         errors;
    int         checks;

    mem_access_if vif ();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_if       (vif),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected store data: narrow data replicated over the word
    function automatic logic [31:0] exp_store(input logic [3:0] sel, input logic [31:0] res);
        if ($countones(sel) == 1) return (res & 32'hFF) * 32'h0101_0101;
        if (sel == 4'b0011 || sel == 4'b1100) return (res & 32'hFFFF) * 32'h0001_0001;
        return res;
    endfunction

    // Expected load data: pick the selected field, shift to bit 0, extend
    function automatic logic [31:0] exp_load(input logic [3:0] sel, input logic [31:0] rd,
                                             input logic sg);
        int          width;
        int          lane;
        logic [31:0] v;
        width = 32;
        v     = rd;
        if (sel == 4'b0011) begin
            v = rd % 65536; width = 16;
        end else if (sel == 4'b1100) begin
            v = rd / 65536; width = 16;
        end else if ($countones(sel) == 1) begin
            lane = $clog2(sel);
            v = (rd >> (8 * lane)) & 32'hFF; width = 8;
        end
        if (width < 32 && sg && v[width-1]) v = v - (32'd1 << width);
        return v;
    endfunction

    task automatic drive_nop();
        vif.mem_memWriteEnable = 1'b0;
        vif.mem_memReadEnable  = 1'b0;
        vif.mem_memAddr        = '0;
        vif.mem_memSel         = '0;
        vif.mem_result         = '0;
        vif.mem_regDest        = '0;
        vif.mem_resultSel      = 1'b0;
        vif.mem_loadSigned     = 1'b0;
    endtask

    // One memory instruction; called at a falling edge, returns at a falling edge
    // once the controller is back in IDLE. waits = BUSY cycles before ack.
    task automatic do_mem(input string name, input logic we, input logic re,
                          input logic [29:0] addr, input logic [3:0] sel,
                          input logic [31:0] result, input logic [4:0] rd,
                          input logic sg, input int waits, input logic [31:0] rdata);
        int   busy, stalls, errs, wbp, exp_req;
        logic timed_out, is_load, exp_wb, done;
        logic [31:0] wb_d;
        logic [4:0]  wb_r;
        busy = 0; stalls = 0; errs = 0; wbp = 0; done = 1'b0;
        wb_d = '0; wb_r = '0;
        timed_out = (waits >= TO);
        exp_req   = timed_out ? TO : waits + 1;
        is_load   = !we;
        exp_wb    = is_load && !timed_out && (rd != 5'd0);
        vif.bus_ack = 1'b0;
        drive_nop();
        @(negedge clk);
        vif.mem_memWriteEnable = we;
        vif.mem_memReadEnable  = re;
        vif.mem_memAddr        = addr;
        vif.mem_memSel         = sel;
        vif.mem_result         = result;
        vif.mem_regDest        = rd;
        vif.mem_resultSel      = 1'b1;
        vif.mem_loadSigned     = sg;
        vif.bus_rdata          = rdata;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (vif.stall_req) stalls++;
            if (vif.bus_err) errs++;
            if (vif.wb_writeEnable) begin
                wbp++; wb_d = vif.wb_data; wb_r = vif.wb_regDest;
            end
            if (vif.bus_req) begin
                busy++;
                checks++;
                if (vif.bus_we !== we || vif.bus_addr !== addr || vif.bus_sel !== sel) begin
                    errors++;
                    $display("FAIL %s bus_cmd: we=%b addr=%h sel=%b expected we=%b addr=%h sel=%b",
                             name, vif.bus_we, vif.bus_addr, vif.bus_sel, we, addr, sel);
                end
                if (we) begin
                    checks++;
                    if (vif.bus_wdata !== exp_store(sel, result)) begin
                        errors++;
                        $display("FAIL %s bus_wdata: got %h expected %h", name, vif.bus_wdata,
                                 exp_store(sel, result));
                    end
                end
                vif.bus_ack = (busy - 1 == waits);
            end else begin
                vif.bus_ack = 1'b0;
            end
            if (busy > 0 && !vif.bus_req) begin
                done = 1'b1;
                checks++;
                if (dbg_state !== 2'd2 || vif.stall_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_cycle: state=%0d stall=%b expected state=2 stall=0",
                             name, dbg_state, vif.stall_req);
                end
                drive_nop();
            end
            @(negedge clk);
            if (done) break;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s completion: bus_req never dropped within 40 cycles", name);
        end
        checks++;
        if (busy != exp_req) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, busy, exp_req);
        end
        checks++;
        if (stalls != exp_req + 1) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_req + 1);
        end
        checks++;
        if (errs != (timed_out ? 1 : 0)) begin
            errors++;
            $display("FAIL %s bus_err_pulses: got %0d expected %0d", name, errs, timed_out ? 1 : 0);
        end
        checks++;
        if (wbp != (exp_wb ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wb_pulses: got %0d expected %0d", name, wbp, exp_wb ? 1 : 0);
        end
        if (exp_wb) begin
            checks++;
            if (wb_d !== exp_load(sel, rdata, sg) || wb_r !== rd) begin
                errors++;
                $display("FAIL %s wb_value: data=%h rd=%0d expected data=%h rd=%0d",
                         name, wb_d, wb_r, exp_load(sel, rdata, sg), rd);
            end
        end
        #1;
        checks++;
        if (dbg_state !== 2'd0 || vif.bus_err !== 1'b0 || vif.stall_req !== 1'b0
            || vif.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: state=%0d err=%b stall=%b req=%b expected 0 0 0 0",
                     name, dbg_state, vif.bus_err, vif.stall_req, vif.bus_req);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (vif.bus_req !== 1'b0 || vif.bus_we !== 1'b0 || vif.bus_err !== 1'b0
            || vif.wb_writeEnable !== 1'b0 || vif.stall_req !== 1'b0
            || vif.bus_addr !== '0 || vif.bus_sel !== '0 || vif.bus_wdata !== '0
            || vif.wb_regDest !== '0 || vif.wb_data !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s reset_values: req=%b we=%b err=%b wbe=%b stall=%b addr=%h sel=%b wdata=%h rd=%0d data=%h state=%0d expected all 0",
                     name, vif.bus_req, vif.bus_we, vif.bus_err, vif.wb_writeEnable,
                     vif.stall_req, vif.bus_addr, vif.bus_sel, vif.bus_wdata,
                     vif.wb_regDest, vif.wb_data, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_nop();
        vif.bus_ack   = 1'b0;
        vif.bus_rdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Back-to-back register ops with a stray ack held high the whole time
    task automatic test_register_ops();
        logic [4:0]  p_rd;
        logic [31:0] p_res;
        logic [4:0]  n_rd;
        logic [31:0] n_res;
        p_rd = '0; p_res = '0;
        vif.bus_ack = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i == 0) begin
                n_rd = 5'd5; n_res = 32'h1234_5678;
            end else if (i == 8) begin
                n_rd = 5'd0; n_res = '0;
            end else begin
                n_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                n_res = $urandom;
            end
            drive_nop();
            vif.mem_regDest = n_rd;
            vif.mem_result  = n_res;
            #1;
            checks++;
            if (vif.stall_req !== 1'b0 || vif.bus_req !== 1'b0) begin
                errors++;
                $display("FAIL regop_nostall[%0d]: stall=%b req=%b expected 0 0", i,
                         vif.stall_req, vif.bus_req);
            end
            if (i > 0) begin
                checks++;
                if (vif.wb_writeEnable !== (p_rd != 5'd0) || vif.wb_regDest !== p_rd
                    || vif.wb_data !== p_res) begin
                    errors++;
                    $display("FAIL regop_wb[%0d]: we=%b rd=%0d data=%h expected we=%b rd=%0d data=%h",
                             i, vif.wb_writeEnable, vif.wb_regDest, vif.wb_data,
                             (p_rd != 5'd0), p_rd, p_res);
                end
            end
            p_rd = n_rd; p_res = n_res;
            @(negedge clk);
        end
        vif.bus_ack = 1'b0;
    endtask

    task automatic test_loads();
        do_mem("load_sb_signed", 1'b0, 1'b1, 30'h0000_0100, 4'b0100, 32'h0, 5'd7, 1'b1, 2,
               32'h0080_0000);
        do_mem("load_sb_unsigned", 1'b0, 1'b1, 30'h0000_0100, 4'b0100, 32'h0, 5'd7, 1'b0, 2,
               32'h0080_0000);
        do_mem("load_hi_half", 1'b0, 1'b1, 30'h0abc_0004, 4'b1100, 32'h0, 5'd3, 1'b1, 0,
               32'h9876_1234);
        do_mem("load_lo_half", 1'b0, 1'b1, 30'h0abc_0005, 4'b0011, 32'h0, 5'd4, 1'b1, 1,
               32'h1234_8001);
        do_mem("load_word", 1'b0, 1'b1, 30'h3fff_ffff, 4'b1111, 32'h0, 5'd31, 1'b1, 0,
               32'hdead_beef);
        do_mem("load_rd0", 1'b0, 1'b1, 30'h0000_0010, 4'b1111, 32'h0, 5'd0, 1'b0, 1,
               32'hcafe_f00d);
    endtask

    task automatic test_stores();
        do_mem("store_half_hi", 1'b1, 1'b0, 30'h0000_0200, 4'b1100, 32'h0000_BEEF, 5'd9, 1'b0, 1,
               32'h0);
        do_mem("store_byte", 1'b1, 1'b0, 30'h0000_0201, 4'b0010, 32'h1234_56A5, 5'd9, 1'b0, 0,
               32'h0);
        do_mem("store_both_en", 1'b1, 1'b1, 30'h0000_0202, 4'b1111, 32'h0bad_f00d, 5'd2, 1'b0, 0,
               32'h1111_1111);
    endtask

    task automatic test_timeout();
        do_mem("load_timeout", 1'b0, 1'b1, 30'h0000_0300, 4'b1111, 32'h0, 5'd6, 1'b0, 100,
               32'h5555_5555);
        do_mem("ack_last_cycle", 1'b0, 1'b1, 30'h0000_0301, 4'b0001, 32'h0, 5'd6, 1'b1, TO - 1,
               32'h0000_00F0);
        do_mem("store_timeout", 1'b1, 1'b0, 30'h0000_0302, 4'b0001, 32'h0000_0077, 5'd6, 1'b0, 100,
               32'h0);
    endtask

    task automatic test_random();
        logic [3:0] sel_tab [8];
        logic       w, r;
        sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110};
        for (int i = 0; i < 12; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            do_mem("random", w, r, 30'($urandom), sel_tab[$urandom_range(0, 7)], $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                   $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        drive_nop();
        vif.bus_ack = 1'b0;
        @(negedge clk);
        vif.mem_memReadEnable = 1'b1;
        vif.mem_memSel        = 4'b1111;
        vif.mem_memAddr       = 30'h0000_0444;
        vif.mem_regDest       = 5'd12;
        vif.mem_resultSel     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (vif.bus_req !== 1'b1 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid setup: req=%b state=%0d expected 1 1", vif.bus_req, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        vif.bus_ack   = 1'b1;
        vif.bus_rdata = 32'hffff_ffff;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (vif.bus_req !== 1'b0 || vif.wb_writeEnable !== 1'b0 || vif.bus_err !== 1'b0
                || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL rst_mid late_ack[%0d]: req=%b wbe=%b err=%b state=%0d expected 0 0 0 0",
                         i, vif.bus_req, vif.wb_writeEnable, vif.bus_err, dbg_state);
            end
        end
        vif.bus_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_register_ops();
        test_loads();
        test_stores();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage memory access controller. Consumes the registered memory command presented by the EX/MEM pipeline register (enables, word address, byte select, result, destination register) and issues it on the data bus using a req/ack handshake. Stalls the pipeline while an access is outstanding, aligns and extends load data, and produces the registered write-back command for the MEM/WB stage.

## Interface
- TIMEOUT, 255: maximum BUSY cycles without `bus_ack` before the access is aborted.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- mem_memWriteEnable  in  1  store command.
- mem_memReadEnable  in  1  load command.
- mem_memAddr  in  30  word address (byte address [31:2]).
- mem_memSel  in  4  byte-lane select; bit i = byte lane [8i+7:8i].
- mem_result  in  32  ALU result (register ops) or store data (stores).
- mem_regDest  in  5  destination register.
- mem_resultSel  in  1  0 = register value passes through, 1 = memory data.
- mem_loadSigned  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- bus_req  out  1  access request, held until ack or timeout.
- bus_we  out  1  1 = write.
- bus_addr  out  30  word address.
- bus_sel  out  4  byte enables.
- bus_wdata  out  32  write data, lane-replicated.
- bus_rdata  in  32  read data, valid with `bus_ack`.
- bus_ack  in  1  one-cycle completion strobe.
- stall_req  out  1  combinational; holds IF..EX/MEM.
- bus_err  out  1  one-cycle pulse on timeout.
- wb_writeEnable  out  1  registered write-back enable.
- wb_regDest  out  5  registered destination.
- wb_data  out  32  registered write-back data.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no enable: pass-through; at edge wb_regDest<=mem_regDest, wb_data<=mem_result, wb_writeEnable<=(mem_regDest!=0). No stall.
- IDLE, enable set: stall_req=1; at edge latch bus_addr/bus_sel/bus_we, bus_req<=1, counter<=0, wb_writeEnable<=0, go BUSY. Write and read both set: treated as write.
- Store data: sel one-hot -> {4{result[7:0]}}; sel 0011/1100 -> {2{result[15:0]}}; else result.
- BUSY: stall_req=1; bus_* held stable. On bus_ack: bus_req<=0, go DONE; load -> wb_writeEnable<=(regDest!=0), wb_data<=aligned rdata; store -> wb_writeEnable stays 0.
- Load align: 1111 raw word; 0011 -> [15:0], 1100 -> [31:16]; one-hot byte -> that lane; then extend per mem_loadSigned. Other sel patterns: raw word.
- Timeout: counter increments each BUSY cycle without ack; at counter==TIMEOUT-1 without ack: bus_req<=0, wb_writeEnable<=0, bus_err<=1 for one cycle, go DONE. Ack in that cycle wins (normal completion, no error).
- DONE: stall_req=0; held input (same instruction) ignored; wb_writeEnable<=0; always -> IDLE next edge.
- bus_ack outside BUSY ignored.

## Timing
- Reset (rst=0 at edge): state IDLE, counter 0, bus_req/bus_we/bus_err/wb_writeEnable 0, bus_addr/bus_sel/bus_wdata/wb_regDest/wb_data 0. Applies mid-access: request dropped immediately, no write-back.
- Register op: wb valid 1 edge after presentation.
- Memory op, ack in first BUSY cycle: cycle 0 IDLE (stall), cycle 1 BUSY (stall, ack), wb valid after edge 1, cycle 2 DONE (no stall), pipeline advances at end of cycle 2. Each extra wait cycle adds one stall cycle.
- wb_writeEnable is a one-cycle pulse per completed load/register op.

## Test plan
- Register op regDest=5, result=0x1234_5678, resultSel=0 -> next cycle wb_writeEnable=1, wb_regDest=5, wb_data=0x1234_5678, stall_req never high.
- Signed byte load sel=0100, rdata=0x00_80_00_00, ack after 2 wait cycles -> bus_req high 3 cycles, wb_data=0xFFFF_FF80; repeat with loadSigned=0 -> 0x0000_0080.
- Halfword store sel=1100, result=0x0000_BEEF -> bus_we=1, bus_wdata=0xBEEF_BEEF, no write-back after ack.
- Load to regDest=0 with ack -> wb_writeEnable stays 0.
- No ack, TIMEOUT=4 -> bus_req high exactly 4 cycles, bus_err 1-cycle pulse, no write-back, DONE then IDLE.
- rst=0 during BUSY -> next cycle bus_req=0, stall_req=0, all outputs at reset values; later ack ignored.
